// File: rtl/seq_detect_pkg.sv
// Shared constants, state encoding and length-mask helper for the programmable pattern detector.
// len_mask covers patterns up to MASK_W bits; PAT_W must not exceed it.
package seq_detect_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int MASK_W    = 64;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_hist_reg.sv
// Bit history shift register plus a count of accepted bits saturating at PAT_W-1.
// clr has priority; fill_clr zeroes the count while the accepted bit still shifts in.
module seq_hist_reg #(
  parameter  int PAT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             fill_clr,
  input  logic             bit_in,
  output logic [PAT_W-2:0] hist,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q, hist_d, shifted;
  logic [LEN_W-1:0] fill_q, fill_d;

  generate
    if (PAT_W > 2) begin : g_wide
      assign shifted = {hist_q[PAT_W-3:0], bit_in};
    end else begin : g_narrow
      assign shifted = bit_in;
    end
  endgenerate

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = shifted;
      if (fill_clr)                fill_d = '0;
      else if (fill_q != FILL_MAX) fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: zero-latency Mealy y, registered y_reg, saturating match_cnt.
// match_cnt/clr_cnt are live only when SEQ_DETECT_CNT_EN is defined; otherwise match_cnt is 0.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             x_valid,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic             y_reg,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [0:0] S_IDLE = ST_IDLE;
  localparam logic [0:0] S_RUN  = ST_RUN;

  logic [0:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic             y_reg_q, y_reg_d;

  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] window, mask;
  logic             cfg_legal, accept, fill_ok;

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  assign accept    = x_valid & ~cfg_load;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      pat_d     = cfg_pat;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      state_d   = cfg_legal ? S_RUN : S_IDLE;
    end
  end

  assign armed = (state_q == S_RUN);

  // Only the newest len bits of {hist, x} take part; len>=1 whenever armed.
  assign window  = {hist, x};
  assign mask    = PAT_W'(len_mask(int'(len_q)));
  assign fill_ok = (fill >= (len_q - LEN_W'(1)));
  assign y       = armed & accept & fill_ok & ((window & mask) == (pat_q & mask));

  assign y_reg_d = y;

  seq_hist_reg #(.PAT_W(PAT_W)) u_hist (
    .clk      (clk),
    .reset    (reset),
    .clr      (cfg_load),
    .shift    (accept),
    .fill_clr (y & ~overlap_q),
    .bit_in   (x),
    .hist     (hist),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      y_reg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      y_reg_q   <= y_reg_d;
    end
  end

  assign y_reg = y_reg_q;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                            cnt_d = '0;
    else if (y && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign match_cnt      = '0;
`endif

endmodule
